// File: rtl/xor_memory_port_scheduler_if.sv
// Requester-side and memory-side signal bundle of the XOR memory port scheduler.
// The scheduler connects through the slave modport.
interface xor_memory_port_scheduler_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int PORTS = 2,
    parameter int REQS  = 4
);
    localparam int AW = $clog2(DEPTH);

    logic [REQS-1:0]             req_valid;
    logic [REQS-1:0]             req_we;
    logic [REQS-1:0][AW-1:0]     req_addr;
    logic [REQS-1:0][WIDTH-1:0]  req_wdata;
    logic [REQS-1:0]             req_ready;
    logic [REQS-1:0]             rsp_valid;
    logic [REQS-1:0][WIDTH-1:0]  rsp_data;
    logic [PORTS-1:0][AW-1:0]    mem_addr;
    logic [PORTS-1:0][WIDTH-1:0] mem_d;
    logic [PORTS-1:0]            mem_en;
    logic [PORTS-1:0][WIDTH-1:0] mem_q;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_q,
        input  req_ready, rsp_valid, rsp_data, mem_addr, mem_d, mem_en
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_q,
        output req_ready, rsp_valid, rsp_data, mem_addr, mem_d, mem_en
    );
endinterface

// File: rtl/xor_memory_port_scheduler.sv
// Round-robin scheduler sharing PORTS XOR-memory ports among REQS requesters,
// with same-address hazard skipping, read-data return and zero-fill after reset or clear.
module xor_memory_port_scheduler #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 256,
    parameter int PORTS       = 2,
    parameter int REQS        = 4,
    parameter int MEM_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    output logic                        init_done,
    xor_memory_port_scheduler_if.slave  bus
);
    localparam int AW         = $clog2(DEPTH);
    localparam int IW         = (REQS > 1) ? $clog2(REQS) : 1;
    localparam int FILL_WORDS = DEPTH / PORTS;
    localparam int FW         = (FILL_WORDS > 1) ? $clog2(FILL_WORDS) : 1;

    typedef enum logic [1:0] {INIT, RUN, DRAIN} state_t;

    state_t                                   state;
    logic [FW-1:0]                            fill_cnt;
    logic [IW-1:0]                            rr_ptr;
    logic [MEM_LATENCY-1:0][PORTS-1:0]        tag_vld;
    logic [MEM_LATENCY-1:0][PORTS-1:0][IW-1:0] tag_idx;

    logic [REQS-1:0]           grant;
    logic [PORTS-1:0]          port_used;
    logic [PORTS-1:0][IW-1:0]  port_req;
    logic [PORTS-1:0]          port_rd;
    logic [IW-1:0]             last_grant;
    logic                      any_grant;

    // Arbitration: one pass from the RR pointer, skipping candidates that collide
    // with an already-granted address when either side writes.
    always_comb begin
        int            n;
        logic [IW-1:0] idx;
        logic          hazard;
        grant      = '0;
        port_used  = '0;
        port_req   = '0;
        port_rd    = '0;
        last_grant = rr_ptr;
        any_grant  = 1'b0;
        n          = 0;
        idx        = '0;
        hazard     = 1'b0;
        if (rst_n && state == RUN && !clear) begin
            for (int j = 0; j < REQS; j++) begin
                idx    = IW'((int'(rr_ptr) + j) % REQS);
                hazard = 1'b0;
                for (int k = 0; k < REQS; k++) begin
                    if (grant[k] && bus.req_addr[k] == bus.req_addr[idx] &&
                        (bus.req_we[k] || bus.req_we[idx]))
                        hazard = 1'b1;
                end
                if (bus.req_valid[idx] && !hazard && n < PORTS) begin
                    grant[idx]   = 1'b1;
                    port_used[n] = 1'b1;
                    port_req[n]  = idx;
                    port_rd[n]   = !bus.req_we[idx];
                    last_grant   = idx;
                    any_grant    = 1'b1;
                    n            = n + 1;
                end
            end
        end
    end

    assign bus.req_ready = grant;

    always_comb begin
        bus.mem_en   = '0;
        bus.mem_addr = '0;
        bus.mem_d    = '0;
        if (rst_n) begin
            for (int p = 0; p < PORTS; p++) begin
                if (state == INIT) begin
                    bus.mem_en[p]   = 1'b1;
                    bus.mem_addr[p] = AW'(fill_cnt) * AW'(PORTS) + AW'(p);
                    bus.mem_d[p]    = {WIDTH{1'b0}};
                end else if (port_used[p]) begin
                    bus.mem_en[p]   = !port_rd[p];
                    bus.mem_addr[p] = bus.req_addr[port_req[p]];
                    bus.mem_d[p]    = port_rd[p] ? {WIDTH{1'b0}} : bus.req_wdata[port_req[p]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= INIT;
            fill_cnt  <= '0;
            rr_ptr    <= '0;
            init_done <= 1'b0;
            tag_vld   <= '0;
        end else begin
            case (state)
                INIT: begin
                    if (fill_cnt == FW'(FILL_WORDS - 1)) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                        fill_cnt  <= '0;
                    end else begin
                        fill_cnt <= fill_cnt + FW'(1);
                    end
                end
                RUN: begin
                    if (clear) begin
                        state     <= DRAIN;
                        init_done <= 1'b0;
                    end
                    if (any_grant)
                        rr_ptr <= (last_grant == IW'(REQS - 1)) ? '0 : last_grant + IW'(1);
                end
                DRAIN: begin
                    if (!(|tag_vld))
                        state <= INIT;
                end
                default: state <= INIT;
            endcase
            // Read-tag pipeline, one stage per cycle of memory latency
            tag_vld[0] <= port_used & port_rd;
            for (int s = 1; s < MEM_LATENCY; s++)
                tag_vld[s] <= tag_vld[s-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_idx[0] <= port_req;
        for (int s = 1; s < MEM_LATENCY; s++)
            tag_idx[s] <= tag_idx[s-1];
    end

    // Response stage: the emerging tag routes its port's mem_q back to the requester
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
        end else begin
            bus.rsp_valid <= '0;
            for (int p = 0; p < PORTS; p++) begin
                if (tag_vld[MEM_LATENCY-1][p]) begin
                    bus.rsp_valid[tag_idx[MEM_LATENCY-1][p]] <= 1'b1;
                    bus.rsp_data[tag_idx[MEM_LATENCY-1][p]]  <= bus.mem_q[p];
                end
            end
        end
    end
endmodule
